sr_cmd_gen: RTL and testbench
=============================

# sr_cmd_gen

Upstream command stage for the `sr_ff` set/reset flip-flop. It turns two raw, asynchronous, bouncy request lines (set and clear buttons or external strobes) into clean, one-cycle `s` and `r` pulses synchronous to `clk`. It guarantees that `s` and `r` are never high together, so the flip-flop never sees the forbidden S=R=1 input. It also counts issued commands and flags conflicting requests.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples needed before a debounced level changes; legal range 1..255.
- `CNT_W`, default 8: width of the issued-command counter.

Ports:
- `clk`  in  1: single system clock; all state changes on its rising edge.
- `rst_n`  in  1: reset; asynchronous assert, active-low.
- `set_req`  in  1: raw set request, asynchronous to `clk`, may bounce.
- `clr_req`  in  1: raw clear request, asynchronous to `clk`, may bounce.
- `s`  out  1: set pulse to `sr_ff`, registered.
- `r`  out  1: reset pulse to `sr_ff`, registered.
- `conflict`  out  1: one-cycle flag; set and clear rising edges were seen in the same cycle.
- `cmd_cnt`  out  CNT_W: number of `s` plus `r` pulses issued, modulo 2^CNT_W.

## Operation
- Each request line goes through a 2-flop synchronizer, then a debouncer, then a rising-edge detector.
- Debouncer holds `deb` (reset 0) and a counter (reset 0).
  - While `sync != deb`, the counter increments each cycle.
  - `deb` takes `sync`, and the counter clears, on the cycle the counter reaches `DEBOUNCE_CYCLES-1` with `sync != deb` still true.
  - Any cycle with `sync == deb` clears the counter. A glitch shorter than `DEBOUNCE_CYCLES` samples therefore produces nothing.
- Edge detector: `set_edge`/`clr_edge` is a 1-cycle pulse when `deb` goes 0 to 1. Falling edges are ignored.
- FSM states: IDLE, S_OUT, R_OUT. `s = (state==S_OUT)` and `r = (state==R_OUT)`, both decoded from registered state.
- Transitions, evaluated the same way in every state:
  - `set_edge & clr_edge` -> IDLE, and `conflict` pulses the next cycle.
  - `set_edge` only -> S_OUT.
  - `clr_edge` only -> R_OUT.
  - No edge -> IDLE.
- Back-to-back edges produce adjacent pulses. Example: S_OUT followed directly by R_OUT gives `s` high for one cycle, then `r` high for one cycle, with no gap.
- `cmd_cnt` increments by 1 in each cycle where `s|r` is high, and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset values: `s=0`, `r=0`, `conflict=0`, `cmd_cnt=0`, state IDLE, all sync/deb/counter flops 0.
- Latency: with a clean request rising before clock edge 0 (setup met), `s` (or `r`) is high from edge `DEBOUNCE_CYCLES+3` to edge `DEBOUNCE_CYCLES+4`. For the default of 4 that is edges 7 to 8.
- Pulse width is exactly 1 cycle, however long the request is held. A new pulse requires release, a debounced low, and a re-press.
- `conflict` has the same latency as `s`/`r`; in that cycle neither `s` nor `r` is high.
- Invariant: `s & r` is never 1 in any cycle, including during and after reset.
- Reset mid-operation: all outputs go to 0 asynchronously, and any pulse in flight is dropped.
  - A request still held high when `rst_n` releases is seen as a fresh press.
  - It produces one pulse `DEBOUNCE_CYCLES+3` edges after the first post-release edge.
- With `DEBOUNCE_CYCLES=1`, the debounced level follows `sync` with one cycle of delay. All other rules are unchanged.

## Structure
- Package `sr_cmd_pkg`:
  - state typedef `sr_cmd_state_t` {IDLE, S_OUT, R_OUT}
  - default debounce constant
- Sub-module `sr_debounce`: synchronizer, debouncer and rise detector for one line, parameterised by `DEBOUNCE_CYCLES`. It is instantiated twice, once for set and once for clear.
- Top `sr_cmd_gen`: FSM, conflict flag, `cmd_cnt`.
- Integration bench instantiates `sr_cmd_gen` driving `sr_ff` on the shared `clk`.

## Test plan
- Clean press: `set_req` rises, held 20 cycles, default params -> exactly one `s` pulse, 7 edges after the press edge; `cmd_cnt=1`; then `clr_req` press -> one `r` pulse, `cmd_cnt=2`, downstream `q` 1 then 0.
- Bounce: `set_req` toggles 1,0,1,0 at 1-cycle spacing, then holds 1 -> no pulse during the bounce; one `s` pulse 7 edges after the final rise.
- Glitch: `clr_req` high for 3 cycles only -> no `r`, `cmd_cnt` unchanged.
- Simultaneous: `set_req` and `clr_req` rise on the same edge -> `conflict` high for 1 cycle at edge 7; `s=r=0` throughout; `cmd_cnt` unchanged.
- Adjacent: `clr_req` rises 1 cycle after `set_req` -> `s` at edge 7, `r` at edge 8, never overlapping; `cmd_cnt` +2.
- Reset and wrap: `rst_n` low mid-debounce with `set_req` held -> outputs 0 immediately; after release, one `s` pulse at edge 7. Separately, with `CNT_W=2`, 5 commands -> `cmd_cnt` reads 1.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the set/reset command generator.
//   sr_cmd_state_t   : command FSM state encoding
//   DEBOUNCE_DEFAULT : default number of stable samples before a level change
//   DEB_CNT_W        : width of the debounce counter (covers 1..255 cycles)
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        S_OUT = 2'd1,
        R_OUT = 2'd2
    } sr_cmd_state_t;

    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int DEB_CNT_W        = 8;

endpackage

// File: rtl/sr_debounce.sv
// Conditions one raw request line: 2-flop synchronizer, debouncer, and a
// registered rising-edge detector on the debounced level.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   req   : raw, asynchronous, possibly bouncing request
//   rise  : one-cycle pulse after the debounced level goes 0 -> 1
module sr_debounce
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic rise
);

    localparam logic [DEB_CNT_W-1:0] TERM_CNT = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 sync_meta;
    logic                 sync;
    logic                 deb;
    logic                 deb_d;
    logic [DEB_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= req;
            sync      <= sync_meta;
        end
    end

    // The counter measures how long sync has disagreed with deb; any
    // agreement restarts the measurement, so short glitches never land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (sync != deb) begin
            if (cnt == TERM_CNT) begin
                deb <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + DEB_CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // Registered edge keeps the pulse free of combinational glitches
    // before it reaches the command FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_d <= 1'b0;
            rise  <= 1'b0;
        end else begin
            deb_d <= deb;
            rise  <= deb & ~deb_d;
        end
    end

endmodule

// File: rtl/sr_cmd_gen.sv
// Command stage ahead of an S/R flip-flop. Converts two raw request lines
// into clean one-cycle s / r pulses that are never high together, flags
// simultaneous set+clear presses, and counts issued commands.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   set_req  : raw set request (asynchronous, may bounce)
//   clr_req  : raw clear request (asynchronous, may bounce)
//   s        : set pulse, decoded from registered state
//   r        : reset pulse, decoded from registered state
//   conflict : one-cycle flag, set and clear edges arrived together
//   cmd_cnt  : number of s plus r pulses issued, wraps at 2^CNT_W
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no command this cycle (also after a conflict)
// S_OUT | s asserted for this single cycle
// R_OUT | r asserted for this single cycle
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_req,
    input  logic             clr_req,
    output logic             s,
    output logic             r,
    output logic             conflict,
    output logic [CNT_W-1:0] cmd_cnt
);

    logic          set_edge;
    logic          clr_edge;
    sr_cmd_state_t state;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (set_req),
        .rise  (set_edge)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (clr_req),
        .rise  (clr_edge)
    );

    // Every state exits after one cycle, so the next state depends only on
    // the edges; this is what keeps each pulse exactly one cycle wide and
    // lets back-to-back commands come out with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            conflict <= 1'b0;
        end else begin
            conflict <= set_edge & clr_edge;
            case ({set_edge, clr_edge})
                2'b10:   state <= S_OUT;
                2'b01:   state <= R_OUT;
                default: state <= IDLE;
            endcase
        end
    end

    // One-hot decode of a single state register: s and r cannot both be 1.
    assign s = (state == S_OUT);
    assign r = (state == R_OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_cnt <= '0;
        end else if (s | r) begin
            cmd_cnt <= cmd_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
module tb_sr_cmd_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       set_req;
    logic       clr_req;
    logic       s_a, r_a, cf_a;
    logic [7:0] cnt_a;
    logic       s_b, r_b, cf_b;
    logic [1:0] cnt_b;
    logic       q_a, q_b;

    sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
        .s(s_a), .r(r_a), .conflict(cf_a), .cmd_cnt(cnt_a)
    );

    sr_cmd_gen #(.DEBOUNCE_CYCLES(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
        .s(s_b), .r(r_b), .conflict(cf_b), .cmd_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    // downstream S/R flip-flops fed by each generator
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a <= 1'b0;
            q_b <= 1'b0;
        end else begin
            if (s_a) q_a <= 1'b1; else if (r_a) q_a <= 1'b0;
            if (s_b) q_b <= 1'b1; else if (r_b) q_b <= 1'b0;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: a debounced level changes once the last D synchronized
    // samples all agree on the new value; a debounced rise turns into a
    // command two edges later; simultaneous rises become a conflict.
    int dcyc[2] = '{4, 1};
    int wid[2]  = '{8, 2};
    bit hs[2][16];
    bit hc[2][16];
    bit ds[2], dc[2];
    bit p1s[2], p2s[2], p1c[2], p2c[2];
    bit es[2], er[2], ecf[2], eq[2];
    int ecnt[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int j = 0; j < 16; j++) begin
                hs[m][j] = 1'b0;
                hc[m][j] = 1'b0;
            end
            ds[m] = 0; dc[m] = 0;
            p1s[m] = 0; p2s[m] = 0; p1c[m] = 0; p2c[m] = 0;
            es[m] = 0; er[m] = 0; ecf[m] = 0; eq[m] = 0;
            ecnt[m] = 0;
        end
    endtask

    task automatic model_step(input bit xs, input bit xc);
        for (int m = 0; m < 2; m++) begin
            bit a1s, a0s, a1c, a0c, nds, ndc, rs, rc;
            for (int j = 15; j > 0; j--) begin
                hs[m][j] = hs[m][j-1];
                hc[m][j] = hc[m][j-1];
            end
            hs[m][0] = xs;
            hc[m][0] = xc;
            // hs[m][j] is the raw sample taken j edges ago; the synchronizer
            // value seen by the debouncer at this edge is the raw sample from
            // two edges ago.
            a1s = 1; a0s = 1; a1c = 1; a0c = 1;
            for (int j = 2; j <= dcyc[m] + 1; j++) begin
                if (hs[m][j]) a0s = 0; else a1s = 0;
                if (hc[m][j]) a0c = 0; else a1c = 0;
            end
            nds = a1s ? 1'b1 : (a0s ? 1'b0 : ds[m]);
            ndc = a1c ? 1'b1 : (a0c ? 1'b0 : dc[m]);
            rs = nds & ~ds[m];
            rc = ndc & ~dc[m];
            ds[m] = nds;
            dc[m] = ndc;
            // effects of the previous cycle's outputs
            if (es[m] | er[m]) ecnt[m] = (ecnt[m] + 1) % (1 << wid[m]);
            if (es[m]) eq[m] = 1'b1; else if (er[m]) eq[m] = 1'b0;
            es[m]  = p2s[m] & ~p2c[m];
            er[m]  = p2c[m] & ~p2s[m];
            ecf[m] = p2s[m] & p2c[m];
            p2s[m] = p1s[m]; p1s[m] = rs;
            p2c[m] = p1c[m]; p1c[m] = rc;
        end
    endtask

    int edge_no, n_s, n_r, n_cf, first_s, first_r, first_cf;

    task automatic scen_start();
        edge_no = -1; n_s = 0; n_r = 0; n_cf = 0;
        first_s = -1; first_r = -1; first_cf = -1;
    endtask

    // Called #1 after an edge; inputs are stable through the next edge.
    task automatic cycle(input bit xs, input bit xc);
        set_req = xs;
        clr_req = xc;
        @(posedge clk);
        model_step(xs, xc);
        edge_no++;
        #1;
        chk("a_s", s_a, es[0]);
        chk("a_r", r_a, er[0]);
        chk("a_conflict", cf_a, ecf[0]);
        chk("a_cmd_cnt", cnt_a, ecnt[0]);
        chk("a_q", q_a, eq[0]);
        chk("a_s_and_r", s_a & r_a, 0);
        chk("b_s", s_b, es[1]);
        chk("b_r", r_b, er[1]);
        chk("b_conflict", cf_b, ecf[1]);
        chk("b_cmd_cnt", cnt_b, ecnt[1]);
        chk("b_q", q_b, eq[1]);
        chk("b_s_and_r", s_b & r_b, 0);
        if (s_a) begin n_s++; if (first_s < 0) first_s = edge_no; end
        if (r_a) begin n_r++; if (first_r < 0) first_r = edge_no; end
        if (cf_a) begin n_cf++; if (first_cf < 0) first_cf = edge_no; end
    endtask

    task automatic hold(input int n, input bit xs, input bit xc);
        for (int i = 0; i < n; i++) cycle(xs, xc);
    endtask

    task automatic do_reset();
        set_req = 0;
        clr_req = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        set_req = 0;
        clr_req = 0;
        model_reset();
        #12;
        chk("rst_a_s", s_a, 0);
        chk("rst_a_r", r_a, 0);
        chk("rst_a_conflict", cf_a, 0);
        chk("rst_a_cmd_cnt", cnt_a, 0);
        chk("rst_b_cmd_cnt", cnt_b, 0);
        @(posedge clk);
        #1 rst_n = 1;
        hold(6, 0, 0);

        // clean set press, then clean clear press
        scen_start();
        hold(20, 1, 0);
        hold(12, 0, 0);
        chk("clean_s_count", n_s, 1);
        chk("clean_s_edge", first_s, 7);
        chk("clean_cnt", cnt_a, 1);
        chk("clean_q_set", q_a, 1);
        scen_start();
        hold(20, 0, 1);
        hold(12, 0, 0);
        chk("clean_r_count", n_r, 1);
        chk("clean_r_edge", first_r, 7);
        chk("clean_cnt2", cnt_a, 2);
        chk("clean_q_clr", q_a, 0);

        // bounce before a steady press
        scen_start();
        cycle(1, 0); cycle(0, 0); cycle(1, 0); cycle(0, 0);
        hold(20, 1, 0);
        hold(12, 0, 0);
        chk("bounce_s_count", n_s, 1);
        chk("bounce_s_edge", first_s, 11);
        chk("bounce_cnt", cnt_a, 3);

        // short glitch on clear
        scen_start();
        hold(3, 0, 1);
        hold(15, 0, 0);
        chk("glitch_r_count", n_r, 0);
        chk("glitch_cnt", cnt_a, 3);

        // simultaneous presses
        scen_start();
        hold(20, 1, 1);
        hold(12, 0, 0);
        chk("simul_cf_count", n_cf, 1);
        chk("simul_cf_edge", first_cf, 7);
        chk("simul_s_count", n_s, 0);
        chk("simul_r_count", n_r, 0);
        chk("simul_cnt", cnt_a, 3);

        // clear one cycle after set
        scen_start();
        cycle(1, 0);
        hold(20, 1, 1);
        hold(12, 0, 0);
        chk("adj_s_edge", first_s, 7);
        chk("adj_r_edge", first_r, 8);
        chk("adj_cnt", cnt_a, 5);
        chk("adj_q", q_a, 0);

        // reset while a set press is mid-debounce
        scen_start();
        hold(3, 1, 0);
        #2 rst_n = 0;
        #1;
        chk("midrst_s", s_a, 0);
        chk("midrst_r", r_a, 0);
        chk("midrst_conflict", cf_a, 0);
        chk("midrst_cnt", cnt_a, 0);
        chk("midrst_cnt_b", cnt_b, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        scen_start();
        hold(20, 1, 0);
        hold(12, 0, 0);
        chk("midrst_s_count", n_s, 1);
        chk("midrst_s_edge", first_s, 7);

        // counter wrap on the narrow-counter instance
        do_reset();
        for (int k = 0; k < 5; k++) begin
            hold(10, 1, 0);
            hold(10, 0, 0);
        end
        chk("wrap_cnt_b", cnt_b, 1);
        chk("wrap_cnt_a", cnt_a, 5);

        // randomized request waveforms against the model
        for (int k = 0; k < 120; k++) begin
            int len;
            bit xs, xc;
            len = $urandom_range(1, 10);
            xs = 1'($urandom_range(0, 1));
            xc = 1'($urandom_range(0, 1));
            hold(len, xs, xc);
        end
        hold(12, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
